// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store sequencer in front of wishbone_master
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_EX_VALID,
   input  logic                  i_EX_LOAD,
   input  logic                  i_EX_STORE,
   input  logic [2:0]            i_EX_FUNCT3,
   input  logic [ADDR_WIDTH-1:0] i_EX_ADDR,
   input  logic [DATA_WIDTH-1:0] i_EX_WDATA,
   input  logic [4:0]            i_EX_RD,
   output logic                  o_STALL,
   output logic                  o_WB_VALID,
   output logic [4:0]            o_WB_RD,
   output logic [DATA_WIDTH-1:0] o_WB_DATA,
   output logic                  o_EXC,
   output logic [3:0]            o_EXC_CAUSE,
   output logic [ADDR_WIDTH-1:0] o_EXC_ADDR,
   output logic                  o_LSU_REQ,
   output logic [ADDR_WIDTH-1:0] o_LSU_ADDR,
   output logic [DATA_WIDTH-1:0] o_LSU_DATA,
   output logic                  o_LSU_WE,
   output logic [1:0]            o_LSU_HB,
   input  logic [DATA_WIDTH-1:0] i_LSU_DATA,
   input  logic                  i_LSU_GNT
);

   typedef enum logic [0:0] {S_IDLE, S_BUS} state_t;

   state_t                state_q;
   logic                  req_q, we_q, uns_q, wb_valid_q, exc_q;
   logic [ADDR_WIDTH-1:0] addr_q, exc_addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, wb_data_q, wb_data_d;
   logic [1:0]            hb_q;
   logic [4:0]            rd_q, wb_rd_q;
   logic [3:0]            exc_cause_q;
   logic                  accept, illegal, misaligned;

   // Classify the op presented by execute; illegal encodings take priority over alignment
   always_comb begin
      accept     = (state_q == S_IDLE) && i_EX_VALID && (i_EX_LOAD || i_EX_STORE);
      illegal    = (i_EX_FUNCT3[1:0] == 2'b11) || (i_EX_FUNCT3 == 3'b110) ||
                   (i_EX_STORE && i_EX_FUNCT3[2]);
      misaligned = ((i_EX_FUNCT3[1:0] == 2'b10) && (i_EX_ADDR[1:0] != 2'b00)) ||
                   ((i_EX_FUNCT3[1:0] == 2'b01) && i_EX_ADDR[0]);
      o_STALL    = (accept && !illegal && !misaligned) ||
                   ((state_q == S_BUS) && !i_LSU_GNT);
   end

   // Zero-extend unsigned sub-word loads; the master already sign-extends signed ones
   always_comb begin
      wb_data_d = i_LSU_DATA;
      if (uns_q && (hb_q == 2'b00)) begin
         wb_data_d = {{(DATA_WIDTH-8){1'b0}}, i_LSU_DATA[7:0]};
      end else if (uns_q && (hb_q == 2'b01)) begin
         wb_data_d = {{(DATA_WIDTH-16){1'b0}}, i_LSU_DATA[15:0]};
      end
   end

   // Two-state sequencer: issue the request, hold it until grant, then return load data
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         hb_q        <= 2'b00;
         rd_q        <= 5'd0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= '0;
         exc_q       <= 1'b0;
         exc_cause_q <= 4'd0;
         exc_addr_q  <= '0;
      end else begin
         wb_valid_q <= 1'b0;
         exc_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     exc_q       <= 1'b1;
                     exc_cause_q <= 4'd2;
                     exc_addr_q  <= i_EX_ADDR;
                  end else if (misaligned) begin
                     exc_q       <= 1'b1;
                     exc_cause_q <= i_EX_LOAD ? 4'd4 : 4'd6;
                     exc_addr_q  <= i_EX_ADDR;
                  end else begin
                     addr_q  <= i_EX_ADDR;
                     wdata_q <= i_EX_WDATA;
                     we_q    <= i_EX_STORE;
                     hb_q    <= i_EX_FUNCT3[1:0];
                     uns_q   <= i_EX_FUNCT3[2];
                     rd_q    <= i_EX_RD;
                     req_q   <= 1'b1;
                     state_q <= S_BUS;
                  end
               end
            end
            S_BUS: begin
               if (i_LSU_GNT) begin
                  req_q   <= 1'b0;
                  state_q <= S_IDLE;
                  if (!we_q) begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= wb_data_d;
                     wb_rd_q    <= rd_q;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_WB_VALID  = wb_valid_q;
   assign o_WB_RD     = wb_rd_q;
   assign o_WB_DATA   = wb_data_q;
   assign o_EXC       = exc_q;
   assign o_EXC_CAUSE = exc_cause_q;
   assign o_EXC_ADDR  = exc_addr_q;
   assign o_LSU_REQ   = req_q;
   assign o_LSU_ADDR  = addr_q;
   assign o_LSU_DATA  = wdata_q;
   assign o_LSU_WE    = we_q;
   assign o_LSU_HB    = hb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_load, ex_store;
   logic [2:0]  ex_f3;
   logic [31:0] ex_addr, ex_wdata;
   logic [4:0]  ex_rd;
   logic        stall, wb_valid, exc, lsu_req, lsu_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, exc_addr, lsu_addr, lsu_data, lsu_rdata;
   logic [3:0]  exc_cause;
   logic [1:0]  lsu_hb;
   logic        lsu_gnt;

   int checks = 0;
   int failures = 0;
   int req_rises = 0, wb_pulses = 0;
   int exp_reqs = 0, exp_wbs = 0;
   logic prev_req = 1'b0;

   load_store_unit dut (
      .i_CLK(clk), .i_RST(rst),
      .i_EX_VALID(ex_valid), .i_EX_LOAD(ex_load), .i_EX_STORE(ex_store),
      .i_EX_FUNCT3(ex_f3), .i_EX_ADDR(ex_addr), .i_EX_WDATA(ex_wdata), .i_EX_RD(ex_rd),
      .o_STALL(stall), .o_WB_VALID(wb_valid), .o_WB_RD(wb_rd), .o_WB_DATA(wb_data),
      .o_EXC(exc), .o_EXC_CAUSE(exc_cause), .o_EXC_ADDR(exc_addr),
      .o_LSU_REQ(lsu_req), .o_LSU_ADDR(lsu_addr), .o_LSU_DATA(lsu_data),
      .o_LSU_WE(lsu_we), .o_LSU_HB(lsu_hb),
      .i_LSU_DATA(lsu_rdata), .i_LSU_GNT(lsu_gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus activity counters and the mutual-exclusion property, sampled mid-cycle
   always @(negedge clk) begin
      if (lsu_req === 1'b1 && prev_req !== 1'b1) req_rises++;
      if (wb_valid === 1'b1) wb_pulses++;
      prev_req = lsu_req;
      checks++;
      assert (!(wb_valid === 1'b1 && exc === 1'b1)) else begin
         failures++;
         $error("FAIL wb_exc_overlap observed=1 expected=0");
      end
   end

   // Reference classification: 0 = legal, otherwise the exception cause
   function automatic int ref_cause(input bit ld, input bit [2:0] f3, input bit [31:0] addr);
      int size;
      if (f3[1:0] == 2'd3 || f3 == 3'd6 || (!ld && f3[2])) return 2;
      size = 1 << f3[1:0];
      if ((addr % size) != 0) return ld ? 4 : 6;
      return 0;
   endfunction

   function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] raw);
      if (f3 == 3'd4) return raw & 32'h0000_00FF;
      if (f3 == 3'd5) return raw & 32'h0000_FFFF;
      return raw;
   endfunction

   task automatic garbage_ex();
      ex_valid = 1'b1;
      ex_load  = 1'($urandom_range(0, 1));
      ex_store = !ex_load;
      ex_f3    = 3'($urandom_range(0, 7));
      ex_addr  = $urandom;
      ex_wdata = $urandom;
      ex_rd    = 5'($urandom_range(0, 31));
   endtask

   // Presents one op in the current cycle and follows it to completion; returns at a
   // cycle where the next op may be presented immediately
   task automatic run_op(input bit ld, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wdata, input bit [4:0] rd, input int gdly,
                         input bit [31:0] rdata);
      int cause;
      cause    = ref_cause(ld, f3, addr);
      ex_valid = 1'b1; ex_load = ld; ex_store = !ld;
      ex_f3 = f3; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
      #1;
      chk("stall_at_accept", 32'(stall), (cause == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      chk("wb_low_after_accept", 32'(wb_valid), 32'd0);
      if (cause != 0) begin
         chk("exc_pulse", 32'(exc), 32'd1);
         chk("exc_cause", 32'(exc_cause), 32'(cause));
         chk("exc_addr", exc_addr, addr);
         chk("no_req_on_exc", 32'(lsu_req), 32'd0);
         return;
      end
      chk("no_exc_legal", 32'(exc), 32'd0);
      exp_reqs++;
      if (ld) exp_wbs++;
      for (int k = 0; k < gdly; k++) begin
         chk("req_held", 32'(lsu_req), 32'd1);
         chk("req_addr", lsu_addr, addr);
         chk("req_we", 32'(lsu_we), ld ? 32'd0 : 32'd1);
         chk("req_hb", 32'(lsu_hb), 32'(f3[1:0]));
         if (!ld) chk("req_data", lsu_data, wdata);
         garbage_ex();
         #1;
         chk("stall_in_bus", 32'(stall), 32'd1);
         @(posedge clk); #1;
      end
      lsu_gnt = 1'b1; lsu_rdata = rdata;
      #1;
      chk("stall_at_gnt", 32'(stall), 32'd0);
      @(posedge clk); #1;
      lsu_gnt = 1'b0; lsu_rdata = $urandom;
      ex_valid = 1'b0;
      chk("req_low_after_gnt", 32'(lsu_req), 32'd0);
      chk("wb_valid", 32'(wb_valid), ld ? 32'd1 : 32'd0);
      chk("exc_quiet_bus", 32'(exc), 32'd0);
      if (ld) begin
         chk("wb_data", wb_data, ref_load(f3, rdata));
         chk("wb_rd", 32'(wb_rd), 32'(rd));
      end
   endtask

   initial begin
      bit ld;
      bit [2:0] f3;
      bit [31:0] a;
      rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_f3 = 3'd0;
      ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0; lsu_rdata = 32'd0; lsu_gnt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(lsu_req), 32'd0);
      chk("rst_we", 32'(lsu_we), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_exc", 32'(exc), 32'd0);
      chk("rst_addr", lsu_addr, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_exc_cause", 32'(exc_cause), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(1, 3'b010, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);   // LW
      run_op(1, 3'b100, 32'h103, 32'h0, 5'd8, 2, 32'hFFFFFF80);   // LBU
      run_op(1, 3'b000, 32'h103, 32'h0, 5'd9, 2, 32'hFFFFFF80);   // LB
      run_op(0, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 3, 32'h0);   // SH
      run_op(1, 3'b010, 32'h101, 32'h0, 5'd3, 2, 32'h0);          // misaligned LW
      run_op(0, 3'b001, 32'h103, 32'h0, 5'd3, 2, 32'h0);          // misaligned SH
      run_op(1, 3'b011, 32'h200, 32'h0, 5'd3, 2, 32'h0);          // illegal funct3
      run_op(1, 3'b101, 32'h202, 32'h0, 5'd0, 2, 32'h8001_8765);  // LHU to x0
      run_op(1, 3'b010, 32'h300, 32'h0, 5'd10, 2, 32'h1111_2222); // back-to-back pair
      run_op(1, 3'b010, 32'h304, 32'h0, 5'd11, 2, 32'h3333_4444);

      // Reset while the bus transaction is outstanding
      ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_f3 = 3'b010;
      ex_addr = 32'h400; ex_rd = 5'd12;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      exp_reqs++;
      chk("midrst_req_up", 32'(lsu_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_req", 32'(lsu_req), 32'd0);
      chk("midrst_addr", lsu_addr, 32'd0);
      chk("midrst_hb", 32'(lsu_hb), 32'd0);
      chk("midrst_wb", 32'(wb_valid), 32'd0);
      chk("midrst_exc", 32'(exc), 32'd0);
      chk("midrst_stall", 32'(stall), 32'd0);
      run_op(1, 3'b010, 32'h500, 32'h0, 5'd13, 2, 32'hCAFE_F00D);

      // Randomized ops checked against the reference rules
      for (int n = 0; n < 150; n++) begin
         ld = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_op(ld, f3, a, $urandom, 5'($urandom_range(0, 31)),
                int'($urandom_range(2, 5)), $urandom);
      end

      @(posedge clk); #1;
      chk("req_count", 32'(req_rises), 32'(exp_reqs));
      chk("wb_count", 32'(wb_pulses), 32'(exp_wbs));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
